// File: rtl/fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fu_wb_arbiter (with package fu_wb_pkg)
//  Summary  : Takes results from NB_FU functional units and holds each one in
//             a small FIFO per unit. The FIFOs drain round-robin, one result
//             per cycle, into a single registered writeback port.
//  Revision : 1.0  initial release
// ============================================================================

package fu_wb_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  id;
        logic [5:0]  prd;
        logic [31:0] rdval;
    } fu_output_t;
endpackage

module fu_wb_arbiter
    import fu_wb_pkg::*;
#(
    parameter int NB_FU = 4,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB_FU-1:0]       fu_valid_i,
    input  fu_output_t [NB_FU-1:0] fu_output_i,
    output logic [NB_FU-1:0]       fu_ready_o,
    input  logic                   flush_i,
    output logic                   wb_valid_o,
    output fu_output_t             wb_o,
    input  logic                   wb_ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (NB_FU > 1) ? $clog2(NB_FU) : 1;

    logic [NB_FU-1:0]       nonempty;
    logic [NB_FU-1:0]       push;
    logic [NB_FU-1:0]       pop;
    fu_output_t [NB_FU-1:0] head;

    logic             load_en;
    logic             any_ready;
    logic             load_any;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_next;

    // Pointers wrap at DEPTH, so the depth does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign load_en   = ~wb_valid_o | wb_ready_i;
    assign any_ready = |nonempty;
    assign load_any  = load_en & any_ready;

    for (genvar k = 0; k < NB_FU; k++) begin : g_fifo
        fu_output_t       mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;

        // Ready comes only from the registered count. A full FIFO refuses a
        // push even when it is popped in the same cycle.
        assign fu_ready_o[k] = (count < CNT_W'(DEPTH));
        assign nonempty[k]   = (count != '0);
        assign push[k]       = fu_valid_i[k] & fu_ready_o[k] & ~flush_i;
        assign pop[k]        = load_any & (grant == IDX_W'(k)) & ~flush_i;
        assign head[k]       = mem[rd_ptr];

        // Result storage. It has no reset because count decides which entries are valid.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem[wr_ptr] <= fu_output_i[k];
            end
        end

        // Occupancy and pointers. A flush clears them.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[k]) wr_ptr <= ptr_inc(wr_ptr);
                if (pop[k])  rd_ptr <= ptr_inc(rd_ptr);
                if (push[k] & ~pop[k]) begin
                    count <= count + 1'b1;
                end else if (~push[k] & pop[k]) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Round-robin scan: grant the first non-empty FU at or after rr_q, wrapping at NB_FU.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        logic             found;
        grant = rr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NB_FU; i++) begin
            sum = {1'b0, rr_q} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NB_FU)) begin
                sum = sum - (IDX_W + 1)'(NB_FU);
            end
            idx = sum[IDX_W-1:0];
            if (!found && nonempty[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign rr_next = (grant == IDX_W'(NB_FU - 1)) ? '0 : grant + 1'b1;

    // Output register. It loads when empty or accepted, and holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            wb_o       <= '0;
            rr_q       <= '0;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
        end else if (load_en) begin
            wb_valid_o <= any_ready;
            if (any_ready) begin
                wb_o <= head[grant];
                rr_q <= rr_next;
            end
        end
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        (push & ~fu_ready_o) == '0);

    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        (pop & ~nonempty) == '0);

    a_wb_stable : assert property (@(posedge clk) disable iff (rst)
        (wb_valid_o && !wb_ready_i && !flush_i) |=> (wb_valid_o && $stable(wb_o)));

endmodule

`default_nettype wire
